keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 142 ++++++++++++++
 tb/tb_keypad_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: drives one column at a time, assembles full-frame row snapshots, debounces
// whole frames and queues single-key press codes in a 4-entry FIFO for a CPU to read.
module keypad_scan #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic       segclk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  input  logic       key_rd,
  input  logic       ovf_clr,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [2:0] key_count,
  output logic       overflow
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]      r_row_s1, r_row_s2;
  logic [DivW-1:0] r_div;
  logic [1:0]      r_col;
  logic [15:0]     r_frame, r_prev, r_stable;
  logic [3:0]      r_match;
  logic            r_push;
  logic [3:0]      r_push_code;
  logic [3:0]      r_mem [4];
  logic [1:0]      r_wptr, r_rptr;
  logic [2:0]      r_count;
  logic            r_ovf;

  logic            w_tc, w_done, w_stable_upd, w_event;
  logic [15:0]     w_frame_new;
  logic [3:0]      w_match_nxt;
  logic [4:0]      w_ones;
  logic [3:0]      w_code;
  logic            w_pop, w_full, w_do_push, w_drop;

  // Two-flop synchronizer for the asynchronous row lines; idle rows read as all-high.
  always_ff @(posedge segclk or posedge reset) begin
    if (reset) begin
      r_row_s1 <= 4'b1111;
      r_row_s2 <= 4'b1111;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_tc   = (r_div == DivW'(SCAN_DIV - 1));
  assign w_done = w_tc && (r_col == 2'd3);

  // Frame as it will look once this cycle's column slice is written.
  always_comb begin
    w_frame_new = r_frame;
    if (w_tc) w_frame_new[{r_col, 2'b00} +: 4] = ~r_row_s2;
  end

  // Match counter next value; saturates at DEB_SCANS-1, clears on any frame difference.
  always_comb begin
    if (w_frame_new != r_prev)                 w_match_nxt = 4'd0;
    else if (r_match == 4'(DEB_SCANS - 1))     w_match_nxt = r_match;
    else                                       w_match_nxt = r_match + 4'd1;
  end

  // Key population and code of the (single) pressed key; bit col*4+row maps to code row*4+col.
  always_comb begin
    w_ones = 5'd0;
    w_code = 4'd0;
    for (int b = 0; b < 16; b++) begin
      w_ones = w_ones + {4'd0, w_frame_new[b]};
      if (w_frame_new[b]) w_code = {2'(b % 4), 2'(b / 4)};
    end
  end

  assign w_stable_upd = w_done && (w_match_nxt == 4'(DEB_SCANS - 1));
  assign w_event      = w_stable_upd && (r_stable == 16'd0) && (w_ones == 5'd1);

  // Column scan divider, frame assembly and frame-level debounce.
  always_ff @(posedge segclk or posedge reset) begin
    if (reset) begin
      r_div       <= '0;
      r_col       <= 2'd0;
      r_frame     <= 16'd0;
      r_prev      <= 16'd0;
      r_stable    <= 16'd0;
      r_match     <= 4'd0;
      r_push      <= 1'b0;
      r_push_code <= 4'd0;
    end else begin
      r_push <= w_event;
      if (w_event) r_push_code <= w_code;
      if (w_tc) begin
        r_div   <= '0;
        r_col   <= r_col + 2'd1;
        r_frame <= w_frame_new;
      end else begin
        r_div <= r_div + DivW'(1);
      end
      if (w_done) begin
        r_prev  <= w_frame_new;
        r_match <= w_match_nxt;
      end
      if (w_stable_upd) r_stable <= w_frame_new;
    end
  end

  assign w_pop     = key_rd && (r_count != 3'd0);
  assign w_full    = (r_count == 3'd4);
  assign w_do_push = r_push && (!w_full || w_pop);
  assign w_drop    = r_push && w_full && !w_pop;

  // Event FIFO with explicit occupancy; a push into a full FIFO is dropped unless a pop coincides.
  always_ff @(posedge segclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 4'd0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= r_push_code;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      if (w_do_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_do_push) r_count <= r_count - 3'd1;
      // A new drop wins over a coincident clear.
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign key_valid = (r_count != 3'd0);
  assign key_code  = key_valid ? r_mem[r_rptr] : 4'd0;
  assign key_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives row_n from a set of pressed keys, and a
// frame-level reference model predicts every output on every cycle.
module tb_keypad_scan;
  localparam int SD  = 4;
  localparam int DEB = 2;

  logic       segclk = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] row_n  = 4'hf;
  logic       key_rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] key_count;
  logic       overflow;

  keypad_scan #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
    .segclk   (segclk),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_rd   (key_rd),
    .ovf_clr  (ovf_clr),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_count(key_count),
    .overflow (overflow)
  );

  always #5 segclk = ~segclk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] pressed = 16'd0;  // bit row*4+col

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: k counts clock edges since reset release.
  int          k = 0;
  logic [3:0]  hist [4];
  logic [15:0] mframe = 0, mprev = 0, mstable = 0;
  int          mmatch = 0;
  bit          mpend = 0;
  int          mpcode = 0;
  int          q[$];
  bit          movf = 0;
  int          mcol;
  int          ecol;
  logic [3:0]  ecoln;

  // Model update on every edge, then compare all outputs just after the edge.
  always @(posedge segclk or posedge reset) begin
    if (reset) begin
      k = 0; mframe = 0; mprev = 0; mstable = 0; mmatch = 0; mpend = 0; movf = 0;
      q.delete();
    end else begin
      k++;
      hist[k % 4] = row_n;
      if (key_rd && q.size() > 0) void'(q.pop_front());
      if (ovf_clr) movf = 0;
      if (mpend) begin
        if (q.size() < 4) q.push_back(mpcode);
        else movf = 1;
      end
      mpend = 0;
      if (k % SD == 0) begin
        mcol = (k / SD - 1) % 4;
        mframe[mcol*4 +: 4] = ~hist[(k - 2) % 4];
        if (mcol == 3) begin
          if (mframe == mprev) begin
            if (mmatch < DEB - 1) mmatch++;
          end else mmatch = 0;
          mprev = mframe;
          if (mmatch == DEB - 1) begin
            if (mstable == 0 && $countones(mframe) == 1) begin
              mpend = 1;
              for (int b = 0; b < 16; b++) if (mframe[b]) mpcode = (b % 4) * 4 + b / 4;
            end
            mstable = mframe;
          end
        end
      end
    end
    #1;
    ecol  = (k / SD) % 4;
    ecoln = 4'b1111 ^ (4'b0001 << ecol);
    chk("col_n", int'(col_n), int'(ecoln));
    chk("key_valid", int'(key_valid), (q.size() > 0) ? 1 : 0);
    chk("key_code", int'(key_code), (q.size() > 0) ? q[0] : 0);
    chk("key_count", int'(key_count), q.size());
    chk("overflow", int'(overflow), int'(movf));
  end

  // Keypad: a pressed key shorts its row to the currently driven column.
  task automatic drive_rows();
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) if (!col_n[i]) c = i;
    for (int r = 0; r < 4; r++) row_n[r] = ~pressed[r*4 + c];
  endtask

  task automatic tick(input bit rd = 0, input bit clr = 0);
    @(negedge segclk);
    key_rd  = rd;
    ovf_clr = clr;
    drive_rows();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  logic [3:0] col_tbl [4];
  int exp_codes [5];

  initial begin
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_codes = '{1, 2, 3, 4, 6};

    // Reset state and column walk
    run(3);
    chk("reset_col_n", int'(col_n), 4'b1110);
    chk("reset_count", int'(key_count), 0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("col_seq", int'(col_n), int'(col_tbl[(i / 4) % 4]));
    end
    run(200);
    chk("idle_valid", int'(key_valid), 0);

    // Single key 9
    pressed = 16'd1 << 9;
    run(64);
    pressed = 0;
    run(48);
    chk("k9_count", int'(key_count), 1);
    chk("k9_code", int'(key_code), 9);
    tick(1);
    tick();
    chk("k9_pop_valid", int'(key_valid), 0);
    chk("k9_pop_code", int'(key_code), 0);
    tick(1);  // read while empty is ignored
    tick();
    chk("empty_rd_count", int'(key_count), 0);

    // Ghost pair 0+5, then key 15
    pressed = (16'd1 << 0) | (16'd1 << 5);
    run(64);
    chk("ghost_count", int'(key_count), 0);
    pressed = 0;
    run(48);
    pressed = 16'd1 << 15;
    run(64);
    pressed = 0;
    run(48);
    chk("k15_code", int'(key_code), 15);
    tick(1);
    tick();

    // Five presses without reads -> overflow
    for (int i = 0; i < 5; i++) begin
      pressed = 16'd1 << exp_codes[i];
      run(64);
      pressed = 0;
      run(48);
    end
    chk("full_count", int'(key_count), 4);
    chk("full_ovf", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", int'(key_code), exp_codes[i]);
      tick(1);
      tick();
    end
    chk("drained_valid", int'(key_valid), 0);
    tick(0, 1);
    tick();
    chk("ovf_cleared", int'(overflow), 0);

    // Bounce on key 10, then steady
    for (int i = 0; i < 48; i++) begin
      pressed = ((i / 3) % 2 == 0) ? (16'd1 << 10) : 16'd0;
      tick();
    end
    pressed = 16'd1 << 10;
    run(64);
    pressed = 0;
    run(48);
    repeat (6) tick(key_valid, 0);
    tick();

    // Reset during the second debounce frame of a held key
    pressed = 16'd1 << 7;
    run(20);
    reset = 1'b1;
    run(2);
    chk("mid_reset_count", int'(key_count), 0);
    reset = 1'b0;
    run(20);
    chk("post_reset_none", int'(key_count), 0);
    run(60);
    chk("post_reset_push", int'(key_count), 1);
    chk("post_reset_code", int'(key_code), 7);
    pressed = 0;
    run(48);

    // Randomized presses, reads and clears
    for (int s = 0; s < 60; s++) begin
      int kind, dur, rate;
      kind = $urandom_range(0, 3);
      dur  = $urandom_range(10, 80);
      rate = ($urandom_range(0, 1) == 0) ? 0 : 5;
      if (kind == 0)      pressed = 0;
      else if (kind == 3) pressed = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
      else                pressed = 16'd1 << $urandom_range(0, 15);
      for (int i = 0; i < dur; i++)
        tick((rate != 0) && ($urandom_range(0, rate - 1) == 0), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        pressed = 0;
        run($urandom_range(16, 64));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
